// File: rtl/latch_sr.sv
// latch_sr: level-sensitive gated SR latch, WIDTH independent bits.
// clk acts as the gate: high = transparent to S/R, low = hold.
// rst is asynchronous, active-high and overrides everything else.
// err is a sticky per-bit flag for S=R=1 applied while transparent;
// it clears on rst or on the next transparent write with S!=R.
// There is no valid/ready handshake and no FSM in this block: the only
// state is one latch bit for Q and one for err per lane.
`timescale 1ns/1ps

module latch_sr #(
   parameter int WIDTH         = 1,
   // 0 = reset-dominant, 1 = set-dominant, 2 = hold previous Q
   parameter int CONFLICT_MODE = 0,
   parameter bit RESET_VALUE   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] R,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] nQ,
   output logic [WIDTH-1:0] err
);

   // Each lane owns its own latch variables so that no vector is written
   // from more than one process.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic q_b;
      logic err_b;

      // Level-sensitive storage: reset first, then transparent update while clk=1.
      always_latch begin
         if (rst) begin
            q_b   <= RESET_VALUE;
            err_b <= 1'b0;
         end else if (clk) begin
            if (S[i] != R[i]) begin
               // Valid write: Q follows S, and any earlier conflict is cleared.
               q_b   <= S[i];
               err_b <= 1'b0;
            end else if (S[i] && R[i]) begin
               err_b <= 1'b1;
               if (CONFLICT_MODE == 0) begin
                  q_b <= 1'b0;
               end else if (CONFLICT_MODE == 1) begin
                  q_b <= 1'b1;
               end
               // CONFLICT_MODE 2 leaves q_b untouched.
            end
            // S=R=0 while transparent: both latches hold.
         end
      end

      assign Q[i]   = q_b;
      // nQ is derived from the same storage bit, so it can never disagree with Q.
      assign nQ[i]  = ~q_b;
      assign err[i] = err_b;
   end

endmodule

// File: tb/tb_latch_sr.sv
// tb_latch_sr: checks three latch_sr instances (one per conflict mode)
// against a rule-level reference model, plus hand-derived vector tables.
`timescale 1ns/1ps

module tb_latch_sr;
   localparam int W = 4;

   // ---------------- clock / reset / stimulus signals ----------------
   logic         clk;
   logic         rst;
   logic [W-1:0] s;
   logic [W-1:0] r;

   logic [W-1:0] q0, nq0, e0;
   logic [W-1:0] q1, nq1, e1;
   logic [W-1:0] q2, nq2, e2;

   latch_sr #(.WIDTH(W), .CONFLICT_MODE(0), .RESET_VALUE(1'b0)) u_m0 (
      .clk(clk), .rst(rst), .S(s), .R(r), .Q(q0), .nQ(nq0), .err(e0));
   latch_sr #(.WIDTH(W), .CONFLICT_MODE(1), .RESET_VALUE(1'b0)) u_m1 (
      .clk(clk), .rst(rst), .S(s), .R(r), .Q(q1), .nQ(nq1), .err(e1));
   latch_sr #(.WIDTH(W), .CONFLICT_MODE(2), .RESET_VALUE(1'b1)) u_m2 (
      .clk(clk), .rst(rst), .S(s), .R(r), .Q(q2), .nQ(nq2), .err(e2));

   // ---------------- reference model ----------------
   int           tests_run;
   int           tests_failed;
   logic [W-1:0] mq [3];
   logic [W-1:0] me [3];
   int           modes [3];
   bit           rvs   [3];

   task automatic model_update();
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            mq[k] = rvs[k] ? '1 : '0;
            me[k] = '0;
         end else if (clk) begin
            for (int b = 0; b < W; b++) begin
               if (s[b] && !r[b]) begin
                  mq[k][b] = 1'b1; me[k][b] = 1'b0;
               end else if (!s[b] && r[b]) begin
                  mq[k][b] = 1'b0; me[k][b] = 1'b0;
               end else if (s[b] && r[b]) begin
                  me[k][b] = 1'b1;
                  if (modes[k] == 0) mq[k][b] = 1'b0;
                  else if (modes[k] == 1) mq[k][b] = 1'b1;
               end
            end
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic cmp(input string name, input logic [3*W-1:0] act, input logic [3*W-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got {Q,nQ,err}=%h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string name);
      cmp({name, "/m0"}, {q0, nq0, e0}, {mq[0], ~mq[0], me[0]});
      cmp({name, "/m1"}, {q1, nq1, e1}, {mq[1], ~mq[1], me[1]});
      cmp({name, "/m2"}, {q2, nq2, e2}, {mq[2], ~mq[2], me[2]});
   endtask

   // ---------------- driver ----------------
   // Inputs are updated together; the model sees the post-change levels,
   // which means a falling gate ignores the simultaneous S/R change and a
   // rising gate applies it.
   task automatic apply(input logic c, input logic rs, input logic [W-1:0] sv,
                        input logic [W-1:0] rv, input int dwell, input string name);
      clk = c; rst = rs; s = sv; r = rv;
      model_update();
      #1;
      check_all(name);
      if (dwell > 1) #(dwell - 1);
   endtask

   // ---------------- vector table for the mode-0 instance ----------------
   typedef struct {
      logic         c;
      logic [W-1:0] sv;
      logic [W-1:0] rv;
      logic [W-1:0] exp_q;
      logic [W-1:0] exp_e;
   } vec_t;

   vec_t tbl [14];

   initial begin
      tests_run = 0; tests_failed = 0;
      modes[0] = 0; modes[1] = 1; modes[2] = 2;
      rvs[0] = 1'b0; rvs[1] = 1'b0; rvs[2] = 1'b1;

      //              clk   S      R      Q      err    (expected for mode 0, RESET_VALUE 0)
      tbl[0]  = '{1'b1, 4'h0, 4'h1, 4'h0, 4'h0};
      tbl[1]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[2]  = '{1'b1, 4'h1, 4'h0, 4'h1, 4'h0};
      tbl[3]  = '{1'b0, 4'h0, 4'h0, 4'h1, 4'h0};
      tbl[4]  = '{1'b1, 4'h0, 4'h1, 4'h0, 4'h0};
      tbl[5]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[6]  = '{1'b1, 4'h5, 4'hA, 4'h5, 4'h0};
      tbl[7]  = '{1'b0, 4'hF, 4'hA, 4'h5, 4'h0};
      tbl[8]  = '{1'b0, 4'hF, 4'hF, 4'h5, 4'h0};
      tbl[9]  = '{1'b1, 4'h3, 4'h3, 4'h4, 4'h3};
      tbl[10] = '{1'b0, 4'h0, 4'h0, 4'h4, 4'h3};
      tbl[11] = '{1'b1, 4'h1, 4'h0, 4'h5, 4'h2};
      tbl[12] = '{1'b1, 4'h2, 4'h0, 4'h7, 4'h0};
      tbl[13] = '{1'b0, 4'h0, 4'h0, 4'h7, 4'h0};

      // Reset held with the gate toggling and S=1: outputs pinned to reset value.
      clk = 1'b1; rst = 1'b1; s = '1; r = '0;
      model_update();
      for (int i = 0; i < 6; i++) begin
         #0.5;
         check_all("rst_hold");
         #0.5;
         clk = ~clk;
         model_update();
      end
      // Release reset mid-transparent phase: Q follows S at once.
      apply(1'b1, 1'b0, 4'h1, 4'h0, 1, "rst_release_transparent");

      // Clear again with the gate closed, then release while closed.
      apply(1'b0, 1'b1, 4'h0, 4'h0, 1, "rst_clear");
      apply(1'b0, 1'b0, 4'h0, 4'h0, 1, "rst_release_hold");

      // Gate-timed sequence: 10 ns period, transitions every 5 ns.
      apply(1'b1, 1'b0, 4'h0, 4'h1, 5, "seq_t0");
      apply(1'b0, 1'b0, 4'h0, 4'h0, 5, "seq_t5");
      apply(1'b1, 1'b0, 4'h1, 4'h0, 5, "seq_t10");
      apply(1'b0, 1'b0, 4'h0, 4'h0, 5, "seq_t15");
      apply(1'b1, 1'b0, 4'h0, 4'h1, 5, "seq_t20");
      apply(1'b0, 1'b0, 4'h0, 4'h0, 5, "seq_t25");
      for (int t = 0; t < 15; t++) begin
         apply(t[0] ? 1'b0 : 1'b1, 1'b0, 4'h0, 4'h0, 5, "seq_hold_to_100");
      end

      // Table-driven vectors, starting from a closed gate with Q=0.
      apply(1'b0, 1'b1, 4'h0, 4'h0, 1, "tbl_pre_rst");
      apply(1'b0, 1'b0, 4'h0, 4'h0, 1, "tbl_pre_rel");
      for (int i = 0; i < 14; i++) begin
         apply(tbl[i].c, 1'b0, tbl[i].sv, tbl[i].rv, 2, $sformatf("tbl%0d", i));
         cmp($sformatf("tbl%0d_vec", i), {q0, nq0, e0}, {tbl[i].exp_q, ~tbl[i].exp_q, tbl[i].exp_e});
      end

      // Gate closed: S and R pulses are ignored; raising the gate applies S at once.
      apply(1'b0, 1'b0, 4'h8, 4'h0, 1, "closed_s_pulse");
      apply(1'b0, 1'b0, 4'h0, 4'hF, 1, "closed_r_pulse");
      apply(1'b0, 1'b0, 4'h0, 4'h0, 1, "closed_idle");
      apply(1'b1, 1'b0, 4'h8, 4'h0, 1, "open_with_s");

      // Conflict then close: err must persist; a valid write clears it.
      apply(1'b1, 1'b0, 4'hF, 4'hF, 1, "conflict_all");
      apply(1'b0, 1'b0, 4'h0, 4'h0, 1, "conflict_closed");
      apply(1'b1, 1'b0, 4'hF, 4'h0, 1, "conflict_clear");

      // Asynchronous reset pulse during hold, no gate activity.
      apply(1'b0, 1'b0, 4'h0, 4'h0, 1, "pre_async");
      rst = 1'b1;
      model_update();
      #0.5;
      check_all("async_rst_mid");
      #0.5;
      rst = 1'b0;
      model_update();
      #1;
      check_all("async_rst_after");

      // Randomized stimulus against the reference model.
      for (int i = 0; i < 300; i++) begin
         apply(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
               4'($urandom), 4'($urandom), $urandom_range(1, 3), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
